sl_seq: RTL and testbench

Sequential logical shift-left unit; the left-direction counterpart to the team's fixed arithmetic right shifters.
- Shifts a WIDTH-bit operand left by a SHW-bit amount.
- Applies one power-of-two stage per clock: 16, 8, 4, 2, 1 for the default width.
- Valid/ready handshake on input and output, so the ALU/shift datapath can share one small iterative shifter instead of a full barrel array.

---
 rtl/sl_seq.sv | 124 ++++++++++++
 tb/tb_sl_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sl_seq.sv
// Iterative logical shift-left unit: one power-of-two stage per clock, valid/ready on both sides.
// Optional rotate-left mode is enabled by defining SL_SEQ_ROTATE_EN (adds port in_rot).
module sl_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic             in_en,
`ifdef SL_SEQ_ROTATE_EN
   input  logic             in_rot,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // SHIFT | applying stages cnt = SHW-1 down to 0, one per clock
   // DONE  | result held on out_data until out_ready
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   amt;
   logic [SHW-1:0]   cnt;
   logic             en_r;
   logic             rot_r;
   logic             accept;
   logic [WIDTH-1:0] stage_arr [SHW];
   logic [WIDTH-1:0] stage_res;
   logic             amt_bit;

   // Each stage has a constant distance, so build every candidate and pick one by cnt.
   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int D = 2 ** k;
      logic [WIDTH-1:0] shl;
      logic [WIDTH-1:0] rol;
      assign shl = acc << D;
      assign rol = {acc[WIDTH-1-D:0], acc[WIDTH-1 -: D]};
      assign stage_arr[k] = rot_r ? rol : shl;
   end

   always_comb begin
      stage_res = acc;
      amt_bit   = 1'b0;
      for (int k = 0; k < SHW; k++) begin
         if (cnt == SHW'(k)) begin
            stage_res = stage_arr[k];
            amt_bit   = amt[k];
         end
      end
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = in_en ? SHIFT : DONE;
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         amt   <= '0;
         cnt   <= SHW'(SHW - 1);
         en_r  <= 1'b0;
         rot_r <= 1'b0;
      end else if (accept) begin
         acc   <= in_data;
         amt   <= in_shamt;
         cnt   <= SHW'(SHW - 1);
         en_r  <= in_en;
`ifdef SL_SEQ_ROTATE_EN
         rot_r <= in_rot;
`else
         rot_r <= 1'b0;
`endif
      end else if (state == SHIFT) begin
         if (en_r & amt_bit) acc <= stage_res;
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   // acc is left untouched after delivery, so the last result stays visible until the next capture.
   assign out_data = acc;

endmodule

// File: tb/tb_sl_seq.sv
// Directed self-checking bench for sl_seq; rotate vectors run only when SL_SEQ_ROTATE_EN is defined.
module tb_sl_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_en;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
`ifdef SL_SEQ_ROTATE_EN
   logic        in_rot;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int lat;
   logic busy_seen;

   sl_seq #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_en     (in_en),
`ifdef SL_SEQ_ROTATE_EN
      .in_rot    (in_rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one operand, accept it, then count edges until out_valid (bounded).
   task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic e, input logic r,
                         output int latency, output logic saw_busy);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_en    = e;
`ifdef SL_SEQ_ROTATE_EN
      in_rot   = r;
`else
      if (r) $display("note: rotate request ignored in this build");
`endif
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'h5555_5555;
      in_shamt = 5'd3;
      latency  = 1;
      saw_busy = busy;
      while (!out_valid && latency < 20) begin
         @(posedge clk);
         @(negedge clk);
         latency++;
         saw_busy = saw_busy | busy;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_en     = 1'b0;
      out_ready = 1'b1;
`ifdef SL_SEQ_ROTATE_EN
      in_rot    = 1'b0;
`endif
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_out_data", out_data, 32'h0);

      // shamt = 31: only bit0 survives, lands at MSB
      run_op(32'h0000_0001, 5'd31, 1'b1, 1'b0, lat, busy_seen);
      check("s31_latency", 32'(lat), 32'd6);
      check("s31_data", out_data, 32'h8000_0000);
      check("s31_busy_seen", 32'(busy_seen), 32'd1);
      check("s31_in_ready_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("s31_reissue_ready", 32'(in_ready), 32'd1);
      check("s31_valid_drop", 32'(out_valid), 32'd0);

      run_op(32'hDEAD_BEEF, 5'd16, 1'b1, 1'b0, lat, busy_seen);
      check("s16_latency", 32'(lat), 32'd6);
      check("s16_data", out_data, 32'hBEEF_0000);

      run_op(32'hDEAD_BEEF, 5'd16, 1'b0, 1'b0, lat, busy_seen);
      check("pass_latency", 32'(lat), 32'd1);
      check("pass_data", out_data, 32'hDEAD_BEEF);
      check("pass_busy_seen", 32'(busy_seen), 32'd0);

      run_op(32'hA5A5_A5A5, 5'd0, 1'b1, 1'b0, lat, busy_seen);
      check("s0_latency", 32'(lat), 32'd6);
      check("s0_data", out_data, 32'hA5A5_A5A5);

      run_op(32'h0000_00FF, 5'd7, 1'b1, 1'b0, lat, busy_seen);
      check("s7_data", out_data, 32'h0000_7F80);

      // back-pressure: result must hold while out_ready is low, stray in_valid ignored
      @(negedge clk);
      out_ready = 1'b0;
      run_op(32'h1234_5678, 5'd4, 1'b1, 1'b0, lat, busy_seen);
      check("bp_latency", 32'(lat), 32'd6);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = 32'hFFFF_0000 + 32'(i);
         in_en    = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_data", out_data, 32'h2345_6780);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_retain_data", out_data, 32'h2345_6780);

      // asynchronous reset in the 3rd SHIFT cycle
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0000_0F0F;
      in_shamt = 5'd8;
      in_en    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", out_data, 32'h0);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(32'h0000_000F, 5'd4, 1'b1, 1'b0, lat, busy_seen);
      check("post_rst_latency", 32'(lat), 32'd6);
      check("post_rst_data", out_data, 32'h0000_00F0);

`ifdef SL_SEQ_ROTATE_EN
      run_op(32'h8000_0001, 5'd1, 1'b1, 1'b1, lat, busy_seen);
      check("rot_latency", 32'(lat), 32'd6);
      check("rot_data", out_data, 32'h0000_0003);
      run_op(32'h8000_0001, 5'd1, 1'b1, 1'b0, lat, busy_seen);
      check("norot_data", out_data, 32'h0000_0002);
      run_op(32'h1234_5678, 5'd20, 1'b1, 1'b1, lat, busy_seen);
      check("rot20_data", out_data, 32'h6781_2345);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
